// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the two-port L1-to-L2 arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int P_ICACHE = 0;
    localparam int P_DCACHE = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the port that was not served last wins.
// Latency: purely combinational.
// Backpressure: none; grant is all-zero when nothing is requested.
// Ports: req[1:0] request bits, last_grant index of the last served port, grant[1:0] one-hot.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the L2's single L1-facing port between the instruction L1 (port 0) and data L1 (port 1).
// Latency: request sampled -> strobe next cycle -> req_ready pulse one cycle after l2_ready (min 3 cycles).
// Backpressure: requests are held by the L1 until its req_ready pulse; the loser simply waits.
// Ports: req_* per-port L1 side (arrays indexed by port), l2_* towards the L2; watchdog aborts after
//        TIMEOUT wait cycles with req_err set (TIMEOUT=0 disables it).
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int BLOCK_SIZE = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            req_addr  [2],
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] req_wdata [2],
    input  logic [1:0]                       req_read,
    input  logic [1:0]                       req_write,
    output logic [1:0]                       req_ready,
    output logic [1:0]                       req_hit,
    output logic [1:0]                       req_valid,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] req_rdata [2],
    output logic [1:0]                       req_err,
    output logic [ADDR_WIDTH-1:0]            l2_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_in,
    output logic                             l2_read,
    output logic                             l2_write,
    input  logic                             l2_ready,
    input  logic                             l2_hit,
    input  logic                             l2_block_valid,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_block_data_out
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t          state, state_nxt;
    op_t             op;
    logic            gnt_idx;
    logic            last_grant;
    logic [CW-1:0]   wd_cnt;
    logic [1:0]      pending;
    logic [1:0]      grant;
    logic            sel;
    logic            timeout_hit;

    assign pending = req_read | req_write;
    assign sel     = grant[P_DCACHE];

    // Abort fires on the edge that would take the counter to TIMEOUT; an
    // l2_ready in that same cycle still wins (checked first below).
    assign timeout_hit = (TIMEOUT != 0) && (int'(wd_cnt) == TIMEOUT - 1);

    rr_arbiter2 u_arb (
        .req        (pending),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (l2_ready || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        l2_read  = (state == ISSUE) && (op == OP_READ);
        l2_write = (state == ISSUE) && (op == OP_WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op           <= OP_READ;
            gnt_idx      <= 1'b0;
            last_grant   <= 1'b1;
            wd_cnt       <= '0;
            l2_addr      <= '0;
            l2_data_in   <= '0;
            req_ready    <= '0;
            req_hit      <= '0;
            req_valid    <= '0;
            req_err      <= '0;
            req_rdata[0] <= '0;
            req_rdata[1] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        gnt_idx    <= sel;
                        // write wins when a port raises both strobes
                        op         <= req_write[sel] ? OP_WRITE : OP_READ;
                        l2_addr    <= req_addr[sel];
                        l2_data_in <= req_wdata[sel];
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    if (l2_ready) begin
                        req_ready[gnt_idx] <= 1'b1;
                        req_err[gnt_idx]   <= 1'b0;
                        req_hit[gnt_idx]   <= l2_hit;
                        req_valid[gnt_idx] <= l2_block_valid;
                        req_rdata[gnt_idx] <= l2_block_data_out;
                        last_grant         <= gnt_idx;
                    end else if (timeout_hit) begin
                        req_ready[gnt_idx] <= 1'b1;
                        req_err[gnt_idx]   <= 1'b1;
                        req_hit[gnt_idx]   <= 1'b0;
                        req_valid[gnt_idx] <= 1'b0;
                        last_grant         <= gnt_idx;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // rdata is deliberately left holding the last block
                    req_ready <= '0;
                    req_hit   <= '0;
                    req_valid <= '0;
                    req_err   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: behavioural L2 responder plus per-port scoreboards.
// Latency: n/a.
// Backpressure: requesters hold their request until req_ready, as the L1s do.
module tb_l2_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int BS = 32;
    localparam int BW = DW * BS;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] req_addr  [2];
    logic [BW-1:0] req_wdata [2];
    logic [1:0]    req_read, req_write;
    logic [1:0]    req_ready, req_hit, req_valid, req_err;
    logic [BW-1:0] req_rdata [2];
    logic [AW-1:0] l2_addr;
    logic [BW-1:0] l2_data_in;
    logic          l2_read, l2_write;
    logic          l2_ready, l2_hit, l2_block_valid;
    logic [BW-1:0] l2_block_data_out;

    always #5 clk = ~clk;

    l2_port_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BLOCK_SIZE (BS),
        .TIMEOUT    (TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_ready         (req_ready),
        .req_hit           (req_hit),
        .req_valid         (req_valid),
        .req_rdata         (req_rdata),
        .req_err           (req_err),
        .l2_addr           (l2_addr),
        .l2_data_in        (l2_data_in),
        .l2_read           (l2_read),
        .l2_write          (l2_write),
        .l2_ready          (l2_ready),
        .l2_hit            (l2_hit),
        .l2_block_valid    (l2_block_valid),
        .l2_block_data_out (l2_block_data_out)
    );

    typedef struct {
        bit            wr;
        bit            err;
        bit            hit;
        bit            valid;
        logic [31:0]   w0;
        logic [AW-1:0] addr;
        logic [31:0]   w3;
    } exp_t;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [31:0]   w3;
        int            cyc;
        int            lat;
    } strb_t;

    exp_t  exp_q0[$];
    exp_t  exp_q1[$];
    int    ord_q[$];
    strb_t strb_q[$];

    int checks  = 0;
    int passes  = 0;
    int cyc     = 0;
    int l2_lat  = 1;
    int strobes = 0;
    int rst_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else passes++;
    endtask

    // L2 model block contents: word i = w0 + i, with w0 = DEADBEEF for address 0x00A.
    function automatic logic [31:0] l2_w0(input logic [AW-1:0] a);
        return 32'hDEADBEEF ^ {21'd0, a ^ 11'h00A};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural L2: l2_lat cycles after a strobe it raises l2_ready for one cycle; 0 = hang.
    initial begin
        strb_t s;
        int    r0;
        l2_ready = 1'b0; l2_hit = 1'b0; l2_block_valid = 1'b0; l2_block_data_out = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (l2_read || l2_write)) begin
                s.wr   = l2_write;
                s.addr = l2_addr;
                s.w3   = l2_data_in[3*DW +: DW];
                s.cyc  = cyc;
                s.lat  = (l2_lat == 0) ? TO + 1 : l2_lat + 1;
                strb_q.push_back(s);
                r0 = rst_cnt;
                if (l2_lat > 0) begin
                    repeat (l2_lat) @(negedge clk);
                    if (r0 == rst_cnt) check("l2_addr_stable", 64'(l2_addr), 64'(s.addr));
                    l2_ready       = 1'b1;
                    l2_hit         = s.addr[0];
                    l2_block_valid = !s.wr;
                    for (int i = 0; i < BS; i++) l2_block_data_out[i*DW +: DW] = l2_w0(s.addr) + 32'(i);
                    @(negedge clk);
                    l2_ready = 1'b0; l2_hit = 1'b0; l2_block_valid = 1'b0;
                end
            end
        end
    end

    task automatic complete(input int p);
        exp_t  e;
        strb_t s;
        int    o = 1 - p;
        bit    have_e = 0;
        check("other_port_quiet", 64'({req_ready[o], req_err[o], req_hit[o], req_valid[o]}), 64'(0));
        if (ord_q.size() == 0) check("ready_expected", 64'(ord_q.size()), 64'(1));
        else check("grant_order", 64'(p), 64'(ord_q.pop_front()));
        if (p == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have_e = 1; end
        if (p == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have_e = 1; end
        if (!have_e) begin
            check("port_req_pending", 64'(have_e), 64'(1));
            return;
        end
        check("resp_err",   64'(req_err[p]),   64'(e.err));
        check("resp_hit",   64'(req_hit[p]),   64'(e.hit));
        check("resp_valid", 64'(req_valid[p]), 64'(e.valid));
        if (!e.err) check("resp_rdata_w0", 64'(req_rdata[p][31:0]), 64'(e.w0));
        if (strb_q.size() == 0) begin
            check("strobe_seen", 64'(strb_q.size()), 64'(1));
        end else begin
            s = strb_q.pop_front();
            check("strobe_is_write", 64'(s.wr),   64'(e.wr));
            check("strobe_addr",     64'(s.addr), 64'(e.addr));
            if (e.wr) check("strobe_wdata_w3", 64'(s.w3), 64'(e.w3));
            check("resp_latency", 64'(cyc - s.cyc), 64'(s.lat));
        end
        check("one_strobe", 64'(strobes), 64'(1));
        strobes = 0;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (l2_read || l2_write) begin
                check("strobe_exclusive", 64'(l2_read & l2_write), 64'(0));
                strobes++;
            end
            for (int p = 0; p < 2; p++) begin
                if (req_ready[p]) complete(p);
                else check("idle_flags", 64'({req_err[p], req_hit[p], req_valid[p]}), 64'(0));
            end
        end
    end

    task automatic request(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [31:0] seed, input bit err);
        exp_t e;
        int   n = 0;
        e.wr    = wr;
        e.err   = err;
        e.hit   = err ? 1'b0 : a[0];
        e.valid = err ? 1'b0 : !wr;
        e.w0    = l2_w0(a);
        e.addr  = a;
        e.w3    = seed ^ 32'd3;
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        req_addr[p] = a;
        for (int i = 0; i < BS; i++) req_wdata[p][i*DW +: DW] = seed ^ 32'(i);
        req_read[p]  = rd;
        req_write[p] = wr;
        while (n < 300) begin
            @(negedge clk);
            if (req_ready[p]) break;
            n++;
        end
        if (n >= 300) check("request_timeout", 64'(n), 64'(0));
        req_read[p]  = 1'b0;
        req_write[p] = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        rst_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_addr[0] = '0; req_addr[1] = '0;
        req_wdata[0] = '0; req_wdata[1] = '0;
        req_read = '0; req_write = '0;

        // Reset values
        @(negedge clk);
        check("rst_req_ready",  64'(req_ready), 64'(0));
        check("rst_req_err",    64'(req_err),   64'(0));
        check("rst_l2_strobes", 64'({l2_read, l2_write}), 64'(0));
        check("rst_l2_addr",    64'(l2_addr), 64'(0));
        check("rst_l2_data",    64'(l2_data_in[63:0]), 64'(0));
        check("rst_rdata1",     64'(req_rdata[1][63:0]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read on port 0
        l2_lat = 2;
        ord_q.push_back(0);
        request(0, 1, 0, 11'h00A, 32'h0, 0);
        repeat (2) @(negedge clk);

        // Simultaneous requests after reset: port 0 first
        reset_dut();
        ord_q.push_back(0); ord_q.push_back(1);
        fork
            request(0, 1, 0, 11'h00A, 32'h0, 0);
            request(1, 0, 1, 11'h014, 32'hA5A5A5A5, 0);
        join

        // Fairness: port 1 served last, so alternation starts at port 0
        l2_lat = 1;
        for (int k = 0; k < 4; k++) begin ord_q.push_back(0); ord_q.push_back(1); end
        fork
            for (int k = 0; k < 4; k++) request(0, 1, 0, 11'(12'h100 + k), 32'h0, 0);
            for (int k = 0; k < 4; k++) request(1, k[0], !k[0], 11'(12'h201 + k), 32'(32'h1000 * k), 0);
        join
        repeat (2) @(negedge clk);

        // Read+write on one port: write wins
        ord_q.push_back(1);
        request(1, 1, 1, 11'h055, 32'h3C3C_0000, 0);
        repeat (2) @(negedge clk);

        // Watchdog abort, then a normal request
        l2_lat = 0;
        ord_q.push_back(0);
        request(0, 1, 0, 11'h077, 32'h0, 1);
        l2_lat = 1;
        ord_q.push_back(0);
        request(0, 1, 0, 11'h078, 32'h0, 0);
        repeat (2) @(negedge clk);

        // Reset in the middle of WAIT
        l2_lat = 5;
        req_addr[0] = 11'h030;
        req_read[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        rst_cnt++;
        req_read[0] = 1'b0;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        check("midrst_l2_addr",   64'(l2_addr), 64'(0));
        check("midrst_l2_data",   64'(l2_data_in[63:0]), 64'(0));
        check("midrst_rdata0",    64'(req_rdata[0][63:0]), 64'(0));
        check("midrst_strobes",   64'({l2_read, l2_write}), 64'(0));
        strb_q.delete();
        strobes = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        l2_lat = 1;
        ord_q.push_back(0); ord_q.push_back(1);
        fork
            request(1, 1, 0, 11'h0F1, 32'h0, 0);
            request(0, 0, 1, 11'h0E0, 32'h5555_0000, 0);
        join
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 64'(exp_q0.size() + exp_q1.size() + ord_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L1-facing port of the L2 cache between two L1 requesters: port 0 is the instruction L1, port 1 is the data L1.
- Accepts block-granular read/write requests from each port and arbitrates round-robin.
- Issues one L2 transaction at a time and routes the L2 response (ready/hit/valid/data) back to the granted port only.
- Includes a watchdog that terminates a hung L2 transaction with an error.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 11, block address width.
- BLOCK_SIZE, 32, words per block; BW = BLOCK_SIZE*DATA_WIDTH.
- TIMEOUT, 255, maximum WAIT cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_addr[0..1]  in  ADDR_WIDTH  per-port request address (two ports, p0/p1).
- req_wdata[0..1]  in  BW  per-port write block.
- req_read[0..1]  in  1  read request; held until the port's ready.
- req_write[0..1]  in  1  write request; held until the port's ready.
- req_ready[0..1]  out  1  one-cycle completion pulse.
- req_hit[0..1]  out  1  L2 hit for the completed transaction; valid with req_ready.
- req_valid[0..1]  out  1  returned block valid; valid with req_ready.
- req_rdata[0..1]  out  BW  returned block; valid with req_ready.
- req_err[0..1]  out  1  watchdog abort; valid with req_ready.
- l2_addr  out  ADDR_WIDTH  to L2 l1_cache_addr.
- l2_data_in  out  BW  to L2 l1_cache_data_in.
- l2_read  out  1  one-cycle read strobe.
- l2_write  out  1  one-cycle write strobe.
- l2_ready  in  1  L2 completion.
- l2_hit  in  1  L2 hit.
- l2_block_valid  in  1  L2 block valid.
- l2_block_data_out  in  BW  L2 read block.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, including l2_addr, l2_data_in and all data buses; last_grant=1, so port 0 wins first; watchdog counter=0. Reset mid-transaction abandons it; no response is delivered.
- Request: a port is pending if req_read|req_write. If both are high on one port, write takes precedence.
- IDLE:
  - No pending port: stay in IDLE.
  - One pending port: grant it.
  - Both pending: grant the port != last_grant.
  - On grant: register grant, op, addr and wdata into l2_addr/l2_data_in; go to ISSUE.
- ISSUE: l2_read or l2_write is 1 for exactly this cycle; go to WAIT; counter cleared.
- WAIT:
  - l2_addr and l2_data_in stay stable.
  - l2_ready=1: register l2_hit, l2_block_valid and l2_block_data_out into the granted port's hit/valid/rdata; req_ready[g]=1; req_err[g]=0; last_grant=g; go to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT (TIMEOUT!=0): req_ready[g]=1, req_err[g]=1, hit=0, valid=0; last_grant=g; go to DONE.
  - l2_ready arriving in the same cycle the counter hits TIMEOUT is treated as normal completion.
- DONE: req_ready, req_err, hit and valid return to 0; rdata holds its value; no arbitration this cycle, so the requester can drop or replace its request; go to IDLE.
- Latency: request sampled at edge E1 → strobe in cycle E1..E2 → earliest l2_ready sampled at E3 → req_ready visible E3..E4. Minimum 3 cycles; back-to-back throughput is one transaction per 4 cycles minimum.
- The non-granted port's outputs stay 0; its request is held and served next.
- l2_ready while in IDLE/ISSUE/DONE is ignored.
- A requester dropping its request mid-transaction is a protocol violation. The L2 transaction still completes and req_ready still pulses.
- Never more than one L2 strobe per transaction; l2_read and l2_write are never high together.

Decomposition:
- Shared package l2_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - op enum {OP_READ, OP_WRITE};
  - port index constants P_ICACHE=0, P_DCACHE=1.
- One sub-module, rr_arbiter2: two request bits and last_grant in, one-hot grant out, purely combinational.
- The watchdog counter stays inline.

Test Plan:
- Single read: p0 read addr 0x00A; L2 raises l2_ready 2 cycles after l2_read with hit=0, valid=1, data[0]=0xDEADBEEF → exactly one l2_read pulse with l2_addr=0x00A; req_ready[0] single pulse with req_rdata[0] word0=0xDEADBEEF, hit=0; port-1 outputs stay 0.
- Simultaneous requests after reset: p0 read 0x00A, p1 write 0x014 with data 0xA5A5A5A5^i, both held → p0 served first, then p1; l2_write carries l2_data_in word3=0xA5A5A5A6; two req_ready pulses, to p0 then p1.
- Fairness: both ports continuously re-request 4 times each → grants alternate 0,1,0,1,...; no port is served twice in a row while the other is pending.
- Read+write on the same port: p1 asserts both → only l2_write pulses; l2_read stays 0.
- Watchdog: TIMEOUT=8, p0 read, l2_ready never asserted → req_ready[0] and req_err[0] pulse 9 cycles after the strobe cycle, with hit=0 and valid=0; the next request proceeds normally.
- Reset mid-WAIT: rst_n low for 1 cycle during WAIT → all outputs 0 immediately; a late l2_ready is ignored; after release, p0 has priority.
